// File: rtl/bin_morph_pkg.sv
// Shared definitions for the binary morphology window path: default image
// geometry, counter widths and the 3-bit window row type.
package bin_morph_pkg;

  localparam int IMG_W_DEFAULT = 8;
  localparam int IMG_H_DEFAULT = 8;
  localparam int COL_W         = $clog2(IMG_W_DEFAULT);
  localparam int ROW_W         = $clog2(IMG_H_DEFAULT);

  // [2] = oldest column (c-2), [0] = newest column (c)
  typedef logic [2:0] win_row_t;

endpackage

// File: rtl/bin_line_buf.sv
// One-line delay for 1-bit pixels: the output is the pixel written DEPTH
// enabled beats ago, i.e. the same column on the previous image line.
module bin_line_buf #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic en_i,
  input  logic d_i,
  output logic d_o
);

  logic [DEPTH-1:0] mem_q;

  // NOTE: storage is deliberately not reset; rows that could expose stale
  // contents never produce a window, and a reset-free array maps to cheaper cells.
  always_ff @(posedge clk) begin
    if (en_i) mem_q <= {mem_q[DEPTH-2:0], d_i};
  end

  assign d_o = mem_q[DEPTH-1];

endmodule

// File: rtl/bin_window_3x3.sv
// 3x3 window generator for binary erosion/dilation over a raster pixel stream.
// Optional output handshake enabled by defining WIN_BACKPRESSURE_EN.
module bin_window_3x3
  import bin_morph_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pix_in,
  input  logic     pix_valid,
  output logic     pix_ready,
`ifdef WIN_BACKPRESSURE_EN
  input  logic     win_ready,
`endif
  output win_row_t q1,
  output win_row_t q2,
  output win_row_t q3,
  output logic     win_valid,
  output logic     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  win_row_t      w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  win_row_t      q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          accept, emit, last_col, last_row;
  logic          lb_a_out, lb_b_out;

  // lb_a yields line r-1 at the current column, lb_b yields line r-2.
  bin_line_buf #(.DEPTH(IMG_W)) u_lb_a (
    .clk  (clk),
    .en_i (accept),
    .d_i  (pix_in),
    .d_o  (lb_a_out)
  );

  bin_line_buf #(.DEPTH(IMG_W)) u_lb_b (
    .clk  (clk),
    .en_i (accept),
    .d_i  (lb_a_out),
    .d_o  (lb_b_out)
  );

`ifdef WIN_BACKPRESSURE_EN
  assign pix_ready = !win_valid_q || win_ready;
`else
  assign pix_ready = 1'b1;
`endif

  assign accept   = pix_valid && pix_ready;
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    q3_d         = q3_q;
    frame_done_d = 1'b0;
`ifdef WIN_BACKPRESSURE_EN
    win_valid_d  = win_valid_q && !win_ready;
`else
    win_valid_d  = 1'b0;
`endif

    if (accept) begin
      col_d        = last_col ? '0 : col_q + 1'b1;
      if (last_col) row_d = last_row ? '0 : row_q + 1'b1;
      frame_done_d = last_col && last_row;
      w1_d         = {w1_q[1:0], lb_b_out};
      w2_d         = {w2_q[1:0], lb_a_out};
      w3_d         = {w3_q[1:0], pix_in};
    end

    if (emit) begin
      q1_d        = w1_d;
      q2_d        = w2_d;
      q3_d        = w3_d;
      win_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      q1_q         <= '0;
      q2_q         <= '0;
      q3_q         <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      q3_q         <= q3_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign q1         = q1_q;
  assign q2         = q2_q;
  assign q3         = q3_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule
